// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_e     FSM encoding (idle / run / hold)
//   RESET_PC_DEFAULT  default first fetch address
//   PcHiW, JumpTargetW, AlignW  slice widths used to form a J-format jump target
//   form_target()     builds {pc_plus4[31:28], target_field, 2'b00}
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned PcHiW       = 4;
  localparam int unsigned JumpTargetW = 26;
  localparam int unsigned AlignW      = 2;

  function automatic logic [31:0] form_target(input logic [PcHiW-1:0]       pc_hi,
                                              input logic [JumpTargetW-1:0] target_field);
    return {pc_hi, target_field, {AlignW{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding buffer for an instruction word and its pc.
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            capture data_i/pc_i (entry becomes valid)
//   pop_i             drop the entry
//   clear_i           drop the entry; wins over load_i and pop_i
//   data_i, pc_i      entry to capture
//   valid_o, data_o, pc_o  current entry
module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/etapa1_fetch.sv
// etapa1_fetch: instruction fetch stage with one-entry skid buffer and J-format redirect.
//   clk, reset         clock, asynchronous active-high reset
//   imem_req/imem_addr request to instruction memory (word-aligned byte address)
//   imem_rdata         read data, valid the cycle after the request cycle
//   instruction, pc, pc_plus4, instr_valid  presented instruction to decode
//   instr_ready        decode accepts the presented instruction
//   jump, jump_target  redirect for the presented instruction (J-format target field)
//   fetch_count, flush_count  transfer / honoured-jump counters, only when the
//                      FETCH_STATS_EN macro is defined
//
// The presented slot is either the output register or, when that register is empty,
// the response arriving this cycle (bypass). This gives a one-cycle request-to-valid
// latency while keeping outputs stable under back-pressure: an unconsumed bypassed
// response is captured into the output register at the end of its cycle.
module etapa1_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instruction,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   jump,
  input  logic [JumpTargetW-1:0] jump_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            flush_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;   // next sequential request address
  logic         pend_q, pend_d;           // a response arrives this cycle
  logic [31:0]  pend_pc_q, pend_pc_d;     // address of that response
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc_q, out_pc_d;

  logic         pres_valid;
  logic [31:0]  pres_instr, pres_pc, pres_pc4;
  logic         jump_taken, consumed, stall;
  logic [31:0]  jump_addr;
  logic         req;
  logic [31:0]  addr;

  logic         skid_load, skid_pop, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_data, skid_pc;

  fetch_skid_buf u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .data_i  (imem_rdata),
    .pc_i    (pend_pc_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  assign pres_valid = out_valid_q | pend_q;
  assign pres_instr = out_valid_q ? out_instr_q : (pend_q ? imem_rdata : 32'h0);
  assign pres_pc    = out_valid_q ? out_pc_q : pend_pc_q;
  assign pres_pc4   = pres_pc + 32'd4;
  assign jump_taken = jump & pres_valid;
  // A redirect consumes the presented instruction regardless of instr_ready.
  assign consumed   = pres_valid & (instr_ready | jump);
  assign jump_addr  = form_target(pres_pc4[31 -: PcHiW], jump_target);
  // Output register full, not leaving, and a response arriving: it must go to the
  // skid buffer, and this cycle's request is withheld so nothing else lands behind it.
  assign stall      = out_valid_q & pend_q & ~consumed;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = 1'b0;
    pend_pc_d   = pend_pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    skid_clear  = 1'b0;
    req         = 1'b0;
    addr        = fetch_pc_q;

    if (jump_taken) begin
      // Arriving response (if not the jumping instruction itself) is dropped.
      req         = 1'b1;
      addr        = jump_addr;
      out_valid_d = 1'b0;
      skid_clear  = 1'b1;
      state_d     = StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
          req     = 1'b1;
          state_d = StRun;
        end
        StRun: begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = StHold;
          end else begin
            req = 1'b1;
            // Capture the response if the register is being vacated, or if it was
            // bypassed into an empty register but not taken.
            if (pend_q && (out_valid_q == consumed)) begin
              out_valid_d = 1'b1;
              out_instr_d = imem_rdata;
              out_pc_d    = pend_pc_q;
            end else if (consumed) begin
              out_valid_d = 1'b0;
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            req         = 1'b1;
            skid_pop    = 1'b1;
            out_valid_d = skid_valid;
            out_instr_d = skid_data;
            out_pc_d    = skid_pc;
            state_d     = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (req) begin
      pend_d     = 1'b1;
      pend_pc_d  = addr;
      fetch_pc_d = addr + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // The idle state requests, so the request is masked while reset is held.
  assign imem_req    = req & ~reset;
  assign imem_addr   = addr;
  assign instruction = pres_instr;
  assign pc          = pres_pc;
  assign pc_plus4    = pres_pc4;
  assign instr_valid = pres_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (pres_valid && instr_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (jump_taken)                flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_etapa1_fetch.sv
// tb_etapa1_fetch: directed checks of etapa1_fetch against hand-computed values.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers address wrap-around.
module tb_etapa1_fetch;

  logic        clk;
  logic        reset;
  logic        instr_ready;
  logic        jump;
  logic [25:0] jump_target;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instruction, pc, pc_plus4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count, w_fetch_count, w_flush_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  etapa1_fetch u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  etapa1_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rdata  (w_rdata),
    .instruction (w_instr),
    .pc          (w_pc),
    .pc_plus4    (w_pc4),
    .instr_valid (w_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (w_fetch_count),
    .flush_count (w_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word at address 0 is the instruction from the bring-up scenario; others encode
  // their own address so any misordering shows up in the data too.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Synchronous memory: data for a request is visible in the following cycle.
  initial begin
    imem_rdata = 32'hDEAD_BEEF;
    w_rdata    = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic jmp, input logic [25:0] jt);
    @(negedge clk);
    instr_ready = rdy;
    jump        = jmp;
    jump_target = jt;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b1;
    jump        = 1'b0;
    jump_target = 26'h0;

    #7;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_w_pc", w_pc, 32'hFFFF_FFFC);

    // Reset release: first cycle requests RESET_PC.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", 32'(instr_valid), 32'd0);
    check("c0_w_addr", w_addr, 32'hFFFF_FFFC);

    cyc(1'b1, 1'b0, 26'h0);  // C1
    check("c1_valid", 32'(instr_valid), 32'd1);
    check("c1_instr", instruction, 32'h2008_0005);
    check("c1_pc", pc, 32'h0);
    check("c1_pc4", pc_plus4, 32'h4);
    check("c1_addr", imem_addr, 32'h4);
    check("c1_w_pc", w_pc, 32'hFFFF_FFFC);
    check("c1_w_pc4", w_pc4, 32'h0);
    check("c1_w_instr", w_instr, 32'hC0DE_FFFC);
    check("c1_w_addr", w_addr, 32'h0);

    cyc(1'b1, 1'b0, 26'h0);  // C2
    check("c2_pc", pc, 32'h4);
    check("c2_instr", instruction, 32'hC0DE_0004);
    check("c2_addr", imem_addr, 32'h8);
    check("c2_w_pc", w_pc, 32'h0);
    check("c2_w_instr", w_instr, 32'h2008_0005);

    // Back-pressure for three cycles while pc 8 is presented.
    cyc(1'b0, 1'b0, 26'h0);  // C3
    check("c3_pc", pc, 32'h8);
    check("c3_instr", instruction, 32'hC0DE_0008);
    check("c3_addr", imem_addr, 32'hC);
    cyc(1'b0, 1'b0, 26'h0);  // C4
    check("c4_pc", pc, 32'h8);
    check("c4_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 26'h0);  // C5
    check("c5_pc", pc, 32'h8);
    check("c5_instr", instruction, 32'hC0DE_0008);
    check("c5_req", 32'(imem_req), 32'd0);
    check("c5_skid_v", 32'(u_dut.u_skid.valid_o), 32'd1);
    check("c5_skid_pc", u_dut.u_skid.pc_o, 32'hC);

    cyc(1'b1, 1'b0, 26'h0);  // C6: release
    check("c6_pc", pc, 32'h8);
    check("c6_req", 32'(imem_req), 32'd1);
    check("c6_addr", imem_addr, 32'h10);
    cyc(1'b1, 1'b0, 26'h0);  // C7
    check("c7_pc", pc, 32'hC);
    check("c7_instr", instruction, 32'hC0DE_000C);
    check("c7_addr", imem_addr, 32'h14);
    cyc(1'b1, 1'b0, 26'h0);  // C8
    check("c8_pc", pc, 32'h10);
    check("c8_instr", instruction, 32'hC0DE_0010);

    // Fill the skid buffer, then jump from the hold state.
    cyc(1'b0, 1'b0, 26'h0);  // C9
    check("c9_pc", pc, 32'h14);
    check("c9_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b1, 26'h20); // C10
    check("c10_skid_v", 32'(u_dut.u_skid.valid_o), 32'd1);
    check("c10_pc", pc, 32'h14);
    check("c10_req", 32'(imem_req), 32'd1);
    check("c10_addr", imem_addr, 32'h80);
    cyc(1'b1, 1'b0, 26'h0);  // C11
    check("c11_valid", 32'(instr_valid), 32'd1);
    check("c11_pc", pc, 32'h80);
    check("c11_instr", instruction, 32'hC0DE_0080);
    check("c11_skid_v", 32'(u_dut.u_skid.valid_o), 32'd0);
    check("c11_addr", imem_addr, 32'h84);
    cyc(1'b1, 1'b0, 26'h0);  // C12
    check("c12_pc", pc, 32'h84);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_pc", pc, 32'h0);
    check("ar_instr", instruction, 32'h0);
    check("ar_req", 32'(imem_req), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("r0_req", 32'(imem_req), 32'd1);
    check("r0_addr", imem_addr, 32'h0);
    check("r0_valid", 32'(instr_valid), 32'd0);
    cyc(1'b1, 1'b0, 26'h0);  // R1
    check("r1_pc", pc, 32'h0);
    check("r1_instr", instruction, 32'h2008_0005);
    cyc(1'b1, 1'b0, 26'h0);  // R2
    check("r2_pc", pc, 32'h4);
    cyc(1'b1, 1'b0, 26'h0);  // R3
    check("r3_pc", pc, 32'h8);

    // Jump from pc 0xC with target field 0x10; ready low so it is not a transfer.
    cyc(1'b0, 1'b1, 26'h10); // R4
    check("r4_pc", pc, 32'hC);
    check("r4_req", 32'(imem_req), 32'd1);
    check("r4_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b0, 26'h0);  // R5
    check("r5_valid", 32'(instr_valid), 32'd1);
    check("r5_pc", pc, 32'h40);
    check("r5_instr", instruction, 32'hC0DE_0040);
    for (int i = 1; i <= 6; i++) begin  // R6..R11
      cyc(1'b1, 1'b0, 26'h0);
      check("seq_pc", pc, 32'h40 + 32'(4 * i));
    end
    cyc(1'b0, 1'b0, 26'h0);  // R12
    check("r12_pc", pc, 32'h5C);
`ifdef FETCH_STATS_EN
    check("fetch_count", fetch_count, 32'd10);
    check("flush_count", flush_count, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/etapa1_fetch.md
ETAPA1_FETCH -- requirements
Module: etapa1_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address; it is word aligned.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port imem_req, output, 1, read request to instruction memory this cycle.
REQ-006 Port imem_addr, output, 32, byte address of the request; bits [1:0] always 0.
REQ-007 Port imem_rdata, input, 32, read data, valid exactly one cycle after the imem_req cycle.
REQ-008 Port instruction, output, 32, instruction presented to the decode stage.
REQ-009 Port pc, output, 32, address of the presented instruction.
REQ-010 Port pc_plus4, output, 32, pc + 4.
REQ-011 Port instr_valid, output, 1, instruction/pc valid.
REQ-012 Port instr_ready, input, 1, decode accepts; transfer when instr_valid && instr_ready.
REQ-013 Port jump, input, 1, redirect request from decode for the presented instruction.
REQ-014 Port jump_target, input, 26, J-format target field.

Function
REQ-015 FSM states SHALL be IDLE, RUN, HOLD: IDLE for exactly the first cycle after reset deassertion, issuing imem_req at RESET_PC, then RUN.
REQ-016 In RUN, one request per cycle SHALL be issued at sequential addresses (+4, wrapping 32'hFFFF_FFFC -> 0).
REQ-017 A response SHALL load the output register when it is empty or consumed the same cycle; otherwise it SHALL load a 1-entry skid buffer and the FSM SHALL enter HOLD.
REQ-018 In HOLD, imem_req SHALL be 0; outputs SHALL remain stable while instr_valid && !instr_ready.
REQ-019 On transfer in HOLD, the skid entry SHALL move to the output register the same cycle and the FSM SHALL return to RUN, issuing the next sequential request that cycle; no instruction SHALL be lost or duplicated.
REQ-020 jump SHALL be honoured only when instr_valid=1; it is ignored otherwise; the presented instruction counts as consumed regardless of instr_ready.
REQ-021 On an honoured jump: target = {pc_plus4[31:28], jump_target, 2'b00}; imem_req SHALL be issued at target that same cycle; imem_rdata that cycle discarded; skid cleared; instr_valid 0 next cycle; FSM to RUN.
REQ-022 Jump-to-valid-target latency SHALL be 1 cycle: instr_valid=1 with pc=target the cycle after the jump cycle.
REQ-023 Sequential fetch-to-valid latency SHALL be 1 cycle from the imem_req cycle.

Reset
REQ-024 Reset SHALL asynchronously force: FSM IDLE, instr_valid 0, instruction 0, pc RESET_PC, pc_plus4 RESET_PC+4, imem_req 0, imem_addr RESET_PC, skid empty, counters 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight and buffered instructions; no response arriving during or after reset SHALL be presented.

Configuration
REQ-026 With macro FETCH_STATS_EN defined, outputs fetch_count (32) and flush_count (32) SHALL exist, counting transfers and honoured jumps, wrapping at 2^32; without it, neither port nor counters SHALL exist and behaviour is otherwise identical.

Structure
REQ-027 FSM state encoding, RESET_PC default and the target-forming slice widths SHALL live in the shared package fetch_pkg.
REQ-028 The skid buffer SHALL be a sub-module fetch_skid_buf (data+pc, 1 entry, load/pop/clear).

Verification
REQ-029 Reset release, memory word 0 = 32'h2008_0005, instr_ready=1 -> imem_req addr 0 in first cycle, next cycle instr_valid with 32'h2008_0005 pc 0, then pc 4, 8 on consecutive cycles.
REQ-030 instr_ready=0 for 3 cycles while pc=8 -> pc 8 held, skid holds pc 12, no request for 16; on release pc 12 then 16 with no gap or duplicate.
REQ-031 jump=1, jump_target=26'h10, pc=32'h0000_000C -> imem_addr 32'h0000_0040 same cycle, pc 0x10 never presented, next valid pc 32'h0000_0040.
REQ-032 jump while skid full (HOLD) -> skid cleared, next valid pc equals target, FSM RUN.
REQ-033 reset asserted asynchronously between clock edges mid-stream -> instr_valid 0 and pc RESET_PC before next edge; restart from RESET_PC.
REQ-034 FETCH_STATS_EN defined, 10 transfers and 1 honoured jump -> fetch_count 10, flush_count 1; undefined build compiles without those ports.
